div_hilo_ctrl: RTL and testbench
================================

// Module: div_hilo_ctrl
// PURPOSE
//   Sequencer and architectural HI/LO holder for DIV. Directly downstream of the iterative divider.
//   Latches operands, restarts the divider and waits its fixed latency, then captures
//   quotient/remainder into HI/LO (or flags div-by-zero). Serves mfhi/mflo/mthi/mtlo and
//   gives the control unit a busy/done handshake.
// PARAMETERS
//   WIDTH        32  operand / HI / LO width
//   DIV_LATENCY  34  cycles the divider needs after its reset pulse; must be >= 34 for the 32-bit divider
//   CNT_W        6   wait-counter width; 2**CNT_W > DIV_LATENCY
// PORTS
//   clk            in   1      rising-edge clock
//   reset          in   1      asynchronous, active-low reset
//   start          in   1      one-cycle DIV request; sampled only in IDLE
//   dividend       in   WIDTH  operand A, sampled with start
//   divisor        in   WIDTH  operand B, sampled with start
//   div_dividend   out  WIDTH  latched operand A to divider
//   div_divisor    out  WIDTH  latched operand B to divider
//   div_reset      out  1      active-high restart pulse to divider
//   div_hi         in   WIDTH  divider remainder
//   div_lo         in   WIDTH  divider quotient
//   div_exception  in   1      divider div-by-zero flag
//   hi_we, lo_we   in   1      mthi / mtlo write strobes
//   wdata          in   WIDTH  mthi/mtlo data
//   rd_sel         in   1      0 = LO, 1 = HI (mflo/mfhi)
//   rd_data        out  WIDTH  combinational read of selected register
//   busy           out  1      operation in flight; control unit stalls
//   done           out  1      one-cycle completion pulse
//   exception      out  1      div-by-zero, sticky until next accepted start
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, HI=LO=0, cnt=0, busy=done=exception=0, operand regs=0.
//     div_reset=1 while reset is low.
//   FSM (all transitions registered):
//     IDLE    -> CLEAR on start. Latch operands, clear exception.
//     CLEAR   div_reset=1 for this cycle, cnt<=0 -> RUN.
//     RUN     cnt++ each cycle; cnt==DIV_LATENCY-1 -> CAPTURE.
//     CAPTURE -> IDLE. div_exception=1: exception<=1, HI/LO unchanged.
//             Else HI<=div_hi, LO<=div_lo. done<=1 in both cases.
//   Latency: start sampled at edge E0; HI/LO written and done high after edge E(DIV_LATENCY+2).
//     busy is high from E0 to E(DIV_LATENCY+2) (busy = state!=IDLE).
//   done is registered, high for exactly one cycle. done and busy are never high together.
//   start while busy: ignored, no queueing.
//   hi_we/lo_we: honoured only in IDLE; ignored while busy.
//     Same IDLE cycle as start: write takes effect and start is accepted; the capture later overwrites.
//   rd_data is HI/LO as currently registered; a value written at an edge is visible after that edge.
//   Reset mid-operation: abort immediately to reset values; no done.
// CONFIGURATION
//   DIV0_SHORTCUT_EN defined: start with divisor==0 skips CLEAR/RUN.
//     IDLE->CAPTURE at E0 with forced exception; done and exception high after E1.
//     busy high for one cycle; HI/LO unchanged.
//   Undefined: zero divisor takes the full path; exception comes from div_exception only.
// STRUCTURE
//   Shared package cpu_div_pkg:
//     state enum {IDLE, CLEAR, RUN, CAPTURE}
//     DIV_LATENCY default
//     RD_LO=1'b0 / RD_HI=1'b1 encodings
//   One natural sub-module, hilo_regs: HI/LO registers, mthi/mtlo/capture write muxing, rd_data read mux.
//   FSM and counter stay in this module.
// TESTING
//   1. start, 100/7; divider model returns 14/2 -> done after E36; LO=14, HI=2, exception=0.
//   2. start, 5/0; model flags exception -> done after E36; exception=1; HI/LO keep prior values.
//      With DIV0_SHORTCUT_EN: done and exception after E1; busy high for 1 cycle.
//   3. Second start at E10 of a busy op with other operands -> ignored; result matches first op; one done only.
//   4. reset low at E20 of a run -> busy=0, HI=LO=0, div_reset=1 immediately; no done; a new op then completes normally.
//   5. lo_we with wdata=32'hDEADBEEF in IDLE, rd_sel=0 -> rd_data=DEADBEEF next cycle.
//      hi_we while busy -> HI unchanged.
//   6. hi_we and start in the same IDLE cycle -> HI=wdata until capture, then HI=div_hi.

Source files
------------

// File: rtl/cpu_div_pkg.sv
// Shared types and constants for the DIV sequencer and its HI/LO register file.
package cpu_div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } div_state_t;

  // Cycles the 32-bit iterative divider needs after its restart pulse.
  localparam int unsigned DEF_DIV_LATENCY = 34;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO registers: divider capture, mthi/mtlo writes, mfhi/mflo read mux.
module hilo_regs
  import cpu_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cap_en,
  input  logic [WIDTH-1:0] cap_hi,
  input  logic [WIDTH-1:0] cap_lo,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Capture and mthi/mtlo cannot coincide: writes are only enabled while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (cap_en) begin
      hi <= cap_hi;
      lo <= cap_lo;
    end else if (wr_en) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  always_comb begin
    rd_data = (rd_sel == RD_HI) ? hi : lo;
  end

endmodule

// File: rtl/div_hilo_ctrl.sv
// DIV sequencer: latches operands, restarts the divider, waits its latency, captures HI/LO.
// Optional DIV0_SHORTCUT_EN: a zero divisor bypasses the divider and flags the exception at once.
module div_hilo_ctrl
  import cpu_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DIV_LATENCY = DEF_DIV_LATENCY,
  parameter int unsigned CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_reset,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  input  logic             div_exception,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             exception
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

  div_state_t       state;
  div_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             exc_now;
  logic             is_idle;

  assign is_idle = (state == IDLE);
  assign accept  = is_idle && start;

`ifdef DIV0_SHORTCUT_EN
  logic force_exc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      force_exc <= 1'b0;
    else if (accept) force_exc <= (divisor == '0);
  end

  assign exc_now = div_exception || force_exc;
`else
  assign exc_now = div_exception;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV0_SHORTCUT_EN
          state_nxt = (divisor == '0) ? CAPTURE : CLEAR;
`else
          state_nxt = CLEAR;
`endif
        end
      end
      CLEAR:   state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      done         <= 1'b0;
      exception    <= 1'b0;
    end else begin
      done <= (state == CAPTURE);
      if (state == CLEAR)    cnt <= '0;
      else if (state == RUN) cnt <= cnt + CNT_W'(1);
      if (accept) begin
        div_dividend <= dividend;
        div_divisor  <= divisor;
        exception    <= 1'b0;
      end else if ((state == CAPTURE) && exc_now) begin
        exception <= 1'b1;
      end
    end
  end

  // The restart pulse is also held while the block itself is in reset.
  assign div_reset = !reset || (state == CLEAR);
  assign busy      = !is_idle;

  hilo_regs #(
    .WIDTH (WIDTH)
  ) u_hilo_regs (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (is_idle),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .cap_en  ((state == CAPTURE) && !exc_now),
    .cap_hi  (div_hi),
    .cap_lo  (div_lo),
    .rd_sel  (rd_sel),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl with a behavioural 34-cycle divider model.
module tb_div_hilo_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_reset;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        div_exception;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        exception;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  int mcnt = 34;
  int n;
  int d0;

  div_hilo_ctrl #(
    .WIDTH       (32),
    .DIV_LATENCY (34),
    .CNT_W       (6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .dividend      (dividend),
    .divisor       (divisor),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_reset     (div_reset),
    .div_hi        (div_hi),
    .div_lo        (div_lo),
    .div_exception (div_exception),
    .hi_we         (hi_we),
    .lo_we         (lo_we),
    .wdata         (wdata),
    .rd_sel        (rd_sel),
    .rd_data       (rd_data),
    .busy          (busy),
    .done          (done),
    .exception     (exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: outputs are junk until 34 edges after the restart pulse.
  always @(posedge clk) begin
    if (div_reset) begin
      mcnt          <= 0;
      div_hi        <= 32'hBAD0_BAD0;
      div_lo        <= 32'hBAD1_BAD1;
      div_exception <= 1'b0;
    end else if (mcnt < 34) begin
      mcnt <= mcnt + 1;
      if (mcnt == 33) begin
        if (div_divisor == 0) begin
          div_exception <= 1'b1;
        end else begin
          div_hi <= div_dividend % div_divisor;
          div_lo <= div_dividend / div_divisor;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done && busy) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
    rd_sel = 1'b1; #1; hi = rd_data;
    rd_sel = 1'b0; #1; lo = rd_data;
  endtask

  // Drive start for exactly one edge (E0); returns just after E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
    chk("busy_after_E0", busy, 1'b1);
  endtask

  // Counts edges since E0 until done is seen, bounded.
  task automatic wait_done(input int from, output int edges);
    edges = from;
    while (!done && edges < 80) begin
      step();
      edges++;
    end
  endtask

  logic [31:0] hv, lv;

  initial begin
    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; rd_sel = 1'b0;
    step(); step();
    chk("rst_div_reset", div_reset, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_exc", exception, 1'b0);
    read_hl(hv, lv);
    chk("rst_hi", hv, 32'h0);
    chk("rst_lo", lv, 32'h0);
    reset = 1'b1;
    step();
    chk("idle_div_reset", div_reset, 1'b0);

    // mtlo in idle, visible after the edge
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    lo_we = 1'b0;
    rd_sel = 1'b0; #1;
    chk("mtlo_rd", rd_data, 32'hDEAD_BEEF);

    // 100 / 7 -> q 14, r 2
    start_op(32'd100, 32'd7);
    chk("oper_a", div_dividend, 32'd100);
    chk("oper_b", div_divisor, 32'd7);
    chk("clear_pulse", div_reset, 1'b1);
    d0 = done_cnt;
    wait_done(0, n);
    chk("lat_100_7", n, 36);
    chk("busy_at_done", busy, 1'b0);
    chk("exc_100_7", exception, 1'b0);
    read_hl(hv, lv);
    chk("hi_100_7", hv, 32'd2);
    chk("lo_100_7", lv, 32'd14);
    step();
    chk("done_one_cycle", done, 1'b0);
    chk("done_pulses_1", done_cnt - d0, 1);

    // 5 / 0 -> exception, HI/LO keep 2/14
    start_op(32'd5, 32'd0);
    wait_done(0, n);
`ifdef DIV0_SHORTCUT_EN
    chk("lat_div0", n, 1);
`else
    chk("lat_div0", n, 36);
`endif
    chk("exc_div0", exception, 1'b1);
    read_hl(hv, lv);
    chk("hi_div0", hv, 32'd2);
    chk("lo_div0", lv, 32'd14);
    step();
    chk("exc_sticky", exception, 1'b1);

    // 1000 / 7 -> q 142, r 6; second start + mthi while busy are ignored
    start_op(32'd1000, 32'd7);
    chk("exc_cleared", exception, 1'b0);
    d0 = done_cnt;
    repeat (9) step();
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    hi_we = 1'b1; wdata = 32'h1234_5678;
    step();
    start = 1'b0; hi_we = 1'b0;
    read_hl(hv, lv);
    chk("hi_we_busy", hv, 32'd2);
    chk("oper_kept", div_divisor, 32'd7);
    wait_done(10, n);
    chk("lat_busy_start", n, 36);
    read_hl(hv, lv);
    chk("hi_1000_7", hv, 32'd6);
    chk("lo_1000_7", lv, 32'd142);
    repeat (40) step();
    chk("single_done", done_cnt - d0, 1);
    chk("no_requeue", busy, 1'b0);

    // reset mid-run aborts without a done
    start_op(32'd100, 32'd7);
    d0 = done_cnt;
    repeat (19) step();
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_div_reset", div_reset, 1'b1);
    read_hl(hv, lv);
    chk("abort_hi", hv, 32'h0);
    chk("abort_lo", lv, 32'h0);
    repeat (20) step();
    chk("abort_no_done", done_cnt - d0, 0);
    reset = 1'b1;
    step();
    start_op(32'd100, 32'd7);
    wait_done(0, n);
    chk("lat_after_abort", n, 36);
    read_hl(hv, lv);
    chk("lo_after_abort", lv, 32'd14);

    // mthi together with start: HI=wdata until capture, then remainder (81/4 -> 20 r 1)
    step();
    hi_we = 1'b1; wdata = 32'h0000_CAFE;
    start_op(32'd81, 32'd4);
    hi_we = 1'b0;
    read_hl(hv, lv);
    chk("hi_we_start", hv, 32'h0000_CAFE);
    wait_done(0, n);
    chk("lat_81_4", n, 36);
    read_hl(hv, lv);
    chk("hi_81_4", hv, 32'd1);
    chk("lo_81_4", lv, 32'd20);

    step();
    chk("done_busy_overlap", overlap_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
